// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : piso_serializer_if
//  Purpose  : Word handshake between the word source and the PISO serializer
//             (parallel data with valid/ready).
//  Revision : 1.0 - initial release
// ============================================================================
interface piso_serializer_if #(
  parameter int WIDTH = 512
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;

  // Word source side
  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  // Serializer side
  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : piso_serializer
//  Purpose  : Parallel-in / serial-out transmitter. Takes one WIDTH-bit word
//             over valid/ready, shifts it out MSB first (one bit per clk) with
//             a frame qualifier, then emits a one-cycle load strobe so the
//             downstream SIPO captures the word.
//  Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
  parameter int WIDTH = 512,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  piso_serializer_if.slave  src_if,
  output logic              o_shift_out,
  output logic              o_frame,
  output logic              o_load_out,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  // Index of the final bit of a word within the bit counter
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic             w_ready;
  logic             w_accept;
  logic             w_last;

  assign w_last            = (r_cnt == C_LAST);
  assign w_accept          = src_if.data_valid && w_ready;
  assign src_if.data_ready = w_ready;

  // The serial bit is the MSB of the shift register. Zeros are shifted in
  // behind the word, so once all bits have left (LOAD, IDLE, after reset)
  // the line sits at 0 without extra gating.
  assign o_shift_out = r_shreg[WIDTH-1];

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    o_frame     = 1'b0;
    o_load_out  = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (src_if.data_valid) begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        o_frame = 1'b1;
        o_busy  = 1'b1;
        if (w_last) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        // Ready during the strobe so a held valid goes straight into the
        // next word with no idle gap.
        w_ready    = 1'b1;
        o_load_out = 1'b1;
        o_busy     = 1'b1;
        w_state_nxt = src_if.data_valid ? S_SHIFT : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Shift register and bit counter: load on accept, shift while in SHIFT
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_shreg <= src_if.data_in;
      r_cnt   <= '0;
    end else if (r_state == S_SHIFT) begin
      r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
      if (!w_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
